// File: rtl/tracker_pkg.sv
// Shared types and defaults for the target-colour paddle tracker.
package tracker_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned COORD_W      = 10;
  localparam int unsigned COORD_SUM_W  = COORD_W + 1;
  localparam int unsigned COUNT_W      = 19;
  localparam int unsigned RUN_W        = 4;
  localparam int unsigned LOST_W       = 8;

  typedef enum logic [1:0] {
    WAIT_SOF,
    ACCUM,
    PUBLISH
  } tracker_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } bbox_t;

  // Empty box: mins at the top of the range so the first qualifying pixel wins.
  localparam bbox_t BBOX_INIT = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0};

  function automatic logic [COORD_W-1:0] midpoint(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    logic [COORD_SUM_W-1:0] sum;
    sum = COORD_SUM_W'(a) + COORD_SUM_W'(b);
    return sum[COORD_W:1];
  endfunction

endpackage

// File: rtl/target_tracker_if.sv
// Raster-in / tracking-results-out bundle between the pixel pipeline and the tracker.
interface target_tracker_if;
  import tracker_pkg::*;

  logic                DE;
  logic [COORD_W-1:0]  x_pixel;
  logic [COORD_W-1:0]  y_pixel;
  logic                is_target_color;

  logic [COORD_W-1:0]  box_x_min;
  logic [COORD_W-1:0]  box_x_max;
  logic [COORD_W-1:0]  box_y_min;
  logic [COORD_W-1:0]  box_y_max;
  logic [COORD_W-1:0]  center_x;
  logic [COORD_W-1:0]  center_y;
  logic [COUNT_W-1:0]  pixel_count;
  logic                valid;
  logic                lost;
  logic                frame_done;

  modport master (
    output DE, x_pixel, y_pixel, is_target_color,
    input  box_x_min, box_x_max, box_y_min, box_y_max,
    input  center_x, center_y, pixel_count, valid, lost, frame_done
  );

  modport slave (
    input  DE, x_pixel, y_pixel, is_target_color,
    output box_x_min, box_x_max, box_y_min, box_y_max,
    output center_x, center_y, pixel_count, valid, lost, frame_done
  );

endinterface

// File: rtl/target_tracker_run_filter.sv
// Horizontal run-length filter: flags target pixels belonging to runs of at least RUN_LEN.
module run_filter
  import tracker_pkg::*;
#(
  parameter int unsigned RUN_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en_i,
  input  logic [COORD_W-1:0] x_pixel_i,
  input  logic               is_target_color_i,
  output logic               qualify_first_c,
  output logic               qualify_cont_c,
  output logic [COORD_W-1:0] run_start_x_c
);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic [RUN_W-1:0] run_base;

  // Column 0 restarts the run before evaluation so runs never wrap across lines.
  always_comb begin
    run_base        = (x_pixel_i == '0) ? '0 : run_q;
    run_d           = run_q;
    qualify_first_c = 1'b0;
    qualify_cont_c  = 1'b0;
    run_start_x_c   = x_pixel_i - COORD_W'(RUN_LEN - 1);
    if (sample_en_i) begin
      if (!is_target_color_i) begin
        run_d = '0;
      end else if (run_base == RUN_W'(RUN_LEN)) begin
        run_d          = run_base;
        qualify_cont_c = 1'b1;
      end else begin
        run_d           = run_base + RUN_W'(1);
        qualify_first_c = (run_d == RUN_W'(RUN_LEN));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) run_q <= '0;
    else       run_q <= run_d;
  end

endmodule

// File: rtl/target_tracker.sv
// Per-frame bounding-box tracker: accumulates filtered target pixels and publishes
// box, centre, count and valid/lost status once per frame.
module target_tracker
  import tracker_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned RUN_LEN     = 4,
  parameter int unsigned MIN_PIXELS  = 64,
  parameter int unsigned LOST_FRAMES = 8
) (
  input  logic             clk,
  input  logic             reset,
  target_tracker_if.slave  trk
);

  tracker_state_e     state_q;
  bbox_t              acc_box_q,   acc_box_d,   base_box;
  logic [COUNT_W-1:0] acc_count_q, acc_count_d, base_count;

  bbox_t              pub_box_q;
  logic [COORD_W-1:0] center_x_q, center_y_q;
  logic [COUNT_W-1:0] pixel_count_q;
  logic               valid_q, lost_q, frame_done_q;
  logic [LOST_W-1:0]  lost_cnt_q, lost_cnt_inc;

  logic               qualify_first, qualify_cont;
  logic [COORD_W-1:0] run_start_x;
  logic               sof, eof, accept;

  run_filter #(.RUN_LEN(RUN_LEN)) u_run_filter (
    .clk              (clk),
    .reset            (reset),
    .sample_en_i      (trk.DE),
    .x_pixel_i        (trk.x_pixel),
    .is_target_color_i(trk.is_target_color),
    .qualify_first_c  (qualify_first),
    .qualify_cont_c   (qualify_cont),
    .run_start_x_c    (run_start_x)
  );

  assign sof    = trk.DE && (trk.x_pixel == '0) && (trk.y_pixel == '0);
  assign eof    = trk.DE && (trk.x_pixel == COORD_W'(H_ACTIVE - 1))
                         && (trk.y_pixel == COORD_W'(V_ACTIVE - 1));
  assign accept = trk.DE && ((state_q != WAIT_SOF) || sof);

  // In PUBLISH the accumulators restart from empty, so an overlapping SOF pixel is kept.
  always_comb begin
    base_box    = (state_q == PUBLISH) ? BBOX_INIT : acc_box_q;
    base_count  = (state_q == PUBLISH) ? '0        : acc_count_q;
    acc_box_d   = base_box;
    acc_count_d = base_count;
    if (accept && (qualify_first || qualify_cont)) begin
      if (qualify_first) begin
        acc_count_d = base_count + COUNT_W'(RUN_LEN);
        if (run_start_x < base_box.x_min) acc_box_d.x_min = run_start_x;
      end else begin
        acc_count_d = base_count + COUNT_W'(1);
      end
      if (trk.x_pixel > base_box.x_max) acc_box_d.x_max = trk.x_pixel;
      if (trk.y_pixel < base_box.y_min) acc_box_d.y_min = trk.y_pixel;
      if (trk.y_pixel > base_box.y_max) acc_box_d.y_max = trk.y_pixel;
    end
  end

  assign lost_cnt_inc = (lost_cnt_q == LOST_W'(LOST_FRAMES)) ? lost_cnt_q
                                                              : lost_cnt_q + LOST_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_SOF;
      acc_box_q     <= BBOX_INIT;
      acc_count_q   <= '0;
      pub_box_q     <= '0;
      center_x_q    <= '0;
      center_y_q    <= '0;
      pixel_count_q <= '0;
      valid_q       <= 1'b0;
      lost_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      lost_cnt_q    <= '0;
    end else begin
      acc_box_q    <= acc_box_d;
      acc_count_q  <= acc_count_d;
      frame_done_q <= 1'b0;
      case (state_q)
        WAIT_SOF: if (sof) state_q <= ACCUM;
        ACCUM:    if (eof) state_q <= PUBLISH;
        PUBLISH: begin
          state_q       <= ACCUM;
          frame_done_q  <= 1'b1;
          pixel_count_q <= acc_count_q;
          if (acc_count_q >= COUNT_W'(MIN_PIXELS)) begin
            valid_q    <= 1'b1;
            lost_cnt_q <= '0;
            lost_q     <= 1'b0;
            pub_box_q  <= acc_box_q;
            center_x_q <= midpoint(acc_box_q.x_min, acc_box_q.x_max);
            center_y_q <= midpoint(acc_box_q.y_min, acc_box_q.y_max);
          end else begin
            valid_q    <= 1'b0;
            lost_cnt_q <= lost_cnt_inc;
            lost_q     <= (lost_cnt_inc == LOST_W'(LOST_FRAMES));
          end
        end
        default: state_q <= WAIT_SOF;
      endcase
    end
  end

  assign trk.box_x_min   = pub_box_q.x_min;
  assign trk.box_x_max   = pub_box_q.x_max;
  assign trk.box_y_min   = pub_box_q.y_min;
  assign trk.box_y_max   = pub_box_q.y_max;
  assign trk.center_x    = center_x_q;
  assign trk.center_y    = center_y_q;
  assign trk.pixel_count = pixel_count_q;
  assign trk.valid       = valid_q;
  assign trk.lost        = lost_q;
  assign trk.frame_done  = frame_done_q;

endmodule
